// File: rtl/fp_alu_pkg.sv
// fp_alu_pkg: operation codes, flag indices and sequencer states shared by the FP ALU front end.
package fp_alu_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    localparam int FLG_OVF = 0;
    localparam int FLG_UNF = 1;
    localparam int FLG_EXC = 2;
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
endpackage

// File: rtl/settle_counter.sv
// settle_counter: loadable 4-bit down-counter with a zero flag.
module settle_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);
    logic [3:0] count_q, count_d;
    always_comb begin
        count_d = load ? load_val : (dec && count_q != 4'd0) ? count_q - 4'd1 : count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) count_q <= 4'd0;
        else     count_q <= count_d;
    end
    assign zero = count_q == 4'd0;
endmodule

// File: rtl/fp_alu_sequencer.sv
// fp_alu_sequencer: registers one request onto the ALU, holds it for a settle window,
// then presents result and flags on a valid/ready response port with sticky status.
module fp_alu_sequencer
    import fp_alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_n1,
    input  logic [31:0]      req_n2,
    input  logic [1:0]       req_oper,
    output logic [31:0]      alu_n1,
    output logic [31:0]      alu_n2,
    output logic [1:0]       alu_oper,
    input  logic [31:0]      alu_result,
    input  logic             alu_overflow,
    input  logic             alu_underflow,
    input  logic             alu_exception,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [2:0]       sticky_flags,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] op_count
);
    state_t           state_q, state_d;
    logic [31:0]      n1_q, n1_d, n2_q, n2_d, res_q, res_d;
    logic [1:0]       oper_q, oper_d;
    logic             rdy_q, rdy_d, vld_q, vld_d, zero, accept, capture;
    logic [2:0]       flg_in, flg_q, flg_d, sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign flg_in[FLG_OVF] = alu_overflow;
    assign flg_in[FLG_UNF] = alu_underflow;
    assign flg_in[FLG_EXC] = alu_exception;
    assign accept  = state_q == IDLE && rdy_q && req_valid;
    assign capture = state_q == SETTLE && zero;

    settle_counter u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .load_val(4'(SETTLE_CYCLES - 1)),
        .dec     (state_q == SETTLE),
        .zero    (zero)
    );

    always_comb begin
        state_d  = accept ? SETTLE : capture ? HOLD : (state_q == HOLD && rsp_ready) ? IDLE : state_q;
        rdy_d    = state_d == IDLE;
        n1_d     = accept ? req_n1 : n1_q;
        n2_d     = accept ? req_n2 : n2_q;
        oper_d   = accept ? req_oper : oper_q;
        vld_d    = capture || (vld_q && !rsp_ready);
        res_d    = capture ? alu_result : res_q;
        flg_d    = capture ? flg_in : flg_q;
        // a clear coinciding with a capture keeps only the new flags
        sticky_d = (sticky_clr ? 3'b000 : sticky_q) | (capture ? flg_in : 3'b000);
        cnt_d    = cnt_q + CNT_W'(capture);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rdy_q    <= 1'b0;
            n1_q     <= '0;
            n2_q     <= '0;
            oper_q   <= OP_ADD;
            vld_q    <= 1'b0;
            res_q    <= '0;
            flg_q    <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            n1_q     <= n1_d;
            n2_q     <= n2_d;
            oper_q   <= oper_d;
            vld_q    <= vld_d;
            res_q    <= res_d;
            flg_q    <= flg_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_ready    = rdy_q;
    assign alu_n1       = n1_q;
    assign alu_n2       = n2_q;
    assign alu_oper     = oper_q;
    assign rsp_valid    = vld_q;
    assign rsp_result   = res_q;
    assign rsp_flags    = flg_q;
    assign sticky_flags = sticky_q;
    assign op_count     = cnt_q;
endmodule

// File: tb/tb_fp_alu_sequencer.sv
// tb_fp_alu_sequencer: directed and random operations against a transaction-level model
// of the sequencer, with a small table-driven ALU stand-in.
module tb_fp_alu_sequencer;
    localparam int S = 3;
    localparam int CW = 2;

    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, sticky_clr = 0;
    logic [31:0] req_n1 = 0, req_n2 = 0, alu_n1, alu_n2, alu_result, rsp_result;
    logic [1:0]  req_oper = 0, alu_oper;
    logic [2:0]  aflags, rsp_flags, sticky_flags;
    logic [CW-1:0] op_count;
    int checks = 0, errors = 0;
    logic [2:0]  stk_m = 0;
    int          cnt_m = 0;

    always #5 clk = ~clk;

    fp_alu_sequencer #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_n1(req_n1), .req_n2(req_n2), .req_oper(req_oper),
        .alu_n1(alu_n1), .alu_n2(alu_n2), .alu_oper(alu_oper),
        .alu_result(alu_result), .alu_overflow(aflags[0]), .alu_underflow(aflags[1]),
        .alu_exception(aflags[2]), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .sticky_flags(sticky_flags),
        .sticky_clr(sticky_clr), .op_count(op_count)
    );

    // ALU stand-in: exact values for the directed cases, a scrambled mix otherwise
    function automatic void alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                                    output logic [31:0] r, output logic [2:0] f);
        f = 3'b000;
        if (a == 32'h3F800000 && b == 32'h40000000 && op == 2'b00) r = 32'h40400000;
        else if (a == 32'h40000000 && b == 32'h40400000 && op == 2'b10) r = 32'h40C00000;
        else if (a == 32'h40C00000 && b == 32'h40000000 && op == 2'b11) r = 32'h40400000;
        else if (a == 32'h7F000000 && op == 2'b10) begin r = 32'h7F800000; f = 3'b001; end
        else if (op == 2'b11 && b == 32'h0) begin r = 32'h7FC00000; f = 3'b100; end
        else begin r = a ^ {b[15:0], b[31:16]} ^ {30'd0, op}; f = a[2:0] & b[2:0]; end
    endfunction

    always_comb alu_ref(alu_n1, alu_n2, alu_oper, alu_result, aflags);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
        check("req_ready_wait", {31'd0, req_ready}, 1);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input int hold, input bit clr);
        logic [31:0] er;
        logic [2:0]  ef;
        int k;
        alu_ref(a, b, op, er, ef);
        wait_ready();
        req_n1 = a; req_n2 = b; req_oper = op; req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
        check("alu_n1", alu_n1, a);
        check("alu_n2", alu_n2, b);
        check("alu_oper", {30'd0, alu_oper}, {30'd0, op});
        cnt_m = (cnt_m + 1) % (1 << CW);
        stk_m = (clr ? 3'b000 : stk_m) | ef;
        k = 0;
        while (!rsp_valid && k < 20) begin
            check("ready_settle", {31'd0, req_ready}, 0);
            if (clr && k == S - 1) sticky_clr = 1;
            @(posedge clk); #1;
            sticky_clr = 0;
            k++;
        end
        check("latency", k, S);
        check("rsp_result", rsp_result, er);
        check("rsp_flags", {29'd0, rsp_flags}, {29'd0, ef});
        check("sticky", {29'd0, sticky_flags}, {29'd0, stk_m});
        check("op_count", {30'd0, op_count}, cnt_m);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1; req_n1 = $urandom; req_n2 = $urandom; req_oper = 2'($urandom);
            @(posedge clk); #1;
            check("hold_valid", {31'd0, rsp_valid}, 1);
            check("hold_result", rsp_result, er);
            check("hold_ready", {31'd0, req_ready}, 0);
            check("hold_alu_n1", alu_n1, a);
            check("hold_alu_n2", alu_n2, b);
        end
        req_valid = 0; rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        check("rsp_drop", {31'd0, rsp_valid}, 0);
        check("ready_back", {31'd0, req_ready}, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, req_ready}, 0);
        check("rst_valid", {31'd0, rsp_valid}, 0);
        check("rst_result", rsp_result, 0);
        check("rst_count", {30'd0, op_count}, 0);
        rst = 0;
        @(posedge clk); #1;
        check("ready_after_rst", {31'd0, req_ready}, 1);
        // abort one cycle into the settle window
        req_n1 = 32'h12345678; req_n2 = 32'h9ABCDEF0; req_oper = 2'b01; req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
        check("abort_alu_n1", alu_n1, 32'h12345678);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("abort_valid", {31'd0, rsp_valid}, 0);
        check("abort_count", {30'd0, op_count}, 0);
        check("abort_alu_n1_rst", alu_n1, 0);
        check("abort_alu_oper_rst", {30'd0, alu_oper}, 0);
        check("abort_sticky", {29'd0, sticky_flags}, 0);
        check("abort_ready", {31'd0, req_ready}, 0);
        repeat (S + 2) begin
            @(posedge clk); #1;
            check("abort_no_rsp", {31'd0, rsp_valid}, 0);
        end
        do_op(32'h40000000, 32'h40400000, 2'b10, 0, 0);
        do_op(32'h40C00000, 32'h40000000, 2'b11, 1, 0);
        do_op(32'h3F800000, 32'h40000000, 2'b00, 0, 0);
        do_op(32'h3F800000, 32'h40000000, 2'b01, 10, 0);
        do_op(32'h7F000000, 32'h40000000, 2'b10, 2, 0);
        do_op(32'h40000000, 32'h00000000, 2'b11, 0, 0);
        do_op(32'h40000000, 32'h00000000, 2'b11, 0, 1);
        for (int i = 0; i < 24; i++)
            do_op($urandom, $urandom, 2'($urandom), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
